// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with optional saturation, valid/ready flow control and sticky overflow
module alu_pipe #(
  parameter int BW = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  input  logic          sat_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [2:0]    flags,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);
  localparam int SW = $clog2(BW);
  localparam logic [BW-1:0] MAX = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] MIN = {1'b1, {(BW-1){1'b0}}};
  logic [BW-1:0] sum, dif, inc, dec, w, res;
  logic signed [BW-1:0] sra;
  logic [SW-1:0] sh;
  logic big, ovf;
  logic v [LAT];
  logic [BW-1:0] r [LAT];
  logic [2:0] f [LAT];
  assign sum = in_a + in_b;
  assign dif = in_a - in_b;
  assign inc = in_a + BW'(1);
  assign dec = in_a - BW'(1);
  assign sh = in_b[SW-1:0];
  // BW is a power of two, so any set bit above the low SW bits means amount >= BW
  assign big = |(in_b >> SW);
  assign sra = $signed(in_a) >>> sh;
  always_comb begin
    w = '0;
    ovf = 1'b0;
    case (opcode)
      4'h0: begin
        w = sum;
        ovf = (in_a[BW-1] == in_b[BW-1]) && (sum[BW-1] != in_a[BW-1]);
      end
      4'h1: begin
        w = dif;
        ovf = (in_a[BW-1] != in_b[BW-1]) && (dif[BW-1] != in_a[BW-1]);
      end
      4'h2: w = in_a & in_b;
      4'h3: w = in_a | in_b;
      4'h4: w = in_a ^ in_b;
      4'h5: begin
        w = inc;
        ovf = in_a == MAX;
      end
      4'h6: w = in_a;
      4'h7: w = in_b;
      4'h8: w = big ? '0 : in_a << sh;
      4'h9: w = big ? '0 : in_a >> sh;
      4'hA: w = big ? {BW{in_a[BW-1]}} : sra;
      4'hB: begin
        w = dec;
        ovf = in_a == MIN;
      end
      default: w = '0;
    endcase
  end
  // overflow direction always follows the sign of operand a for add/sub/inc/dec
  assign res = (sat_en && ovf) ? (in_a[BW-1] ? MIN : MAX) : w;
  assign in_ready = !out_valid | out_ready;
  assign out_valid = v[LAT-1];
  assign out = r[LAT-1];
  assign flags = f[LAT-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        v[i] <= 1'b0;
        r[i] <= '0;
        f[i] <= '0;
      end
      ovf_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        v[0] <= in_valid;
        r[0] <= res;
        f[0] <= {ovf, res[BW-1], res == '0};
        for (int i = 1; i < LAT; i++) begin
          v[i] <= v[i-1];
          r[i] <= r[i-1];
          f[i] <= f[i-1];
        end
      end
      if (out_valid && out_ready && flags[2]) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with directed corner cases and random back-pressure
module tb_alu_pipe;
  localparam int BW = 16;
  localparam int LAT = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [BW-1:0] in_a = '0, in_b = '0;
  logic [3:0] opcode = '0;
  logic sat_en = 0;
  logic out_valid;
  logic out_ready = 1;
  logic [BW-1:0] out;
  logic [2:0] flags;
  logic ovf_sticky;
  logic ovf_clr = 0;
  int n_chk = 0, n_fail = 0, n_out = 0;
  logic [18:0] q[$];

  alu_pipe #(.BW(BW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference computed with integer arithmetic, overflow from the true range
  function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic s);
    int sa, sb, t;
    logic [15:0] rr;
    logic o, ar;
    sa = $signed(a);
    sb = $signed(b);
    t = 0;
    rr = 0;
    o = 0;
    ar = 1;
    case (op)
      4'd0: t = sa + sb;
      4'd1: t = sa - sb;
      4'd5: t = sa + 1;
      4'd11: t = sa - 1;
      default: ar = 0;
    endcase
    if (ar) begin
      o = (t > 32767) || (t < -32768);
      rr = t[15:0];
      if (s && o) rr = (t > 0) ? 16'h7fff : 16'h8000;
    end else begin
      case (op)
        4'd2: rr = a & b;
        4'd3: rr = a | b;
        4'd4: rr = a ^ b;
        4'd6: rr = a;
        4'd7: rr = b;
        4'd8: rr = (b >= 16) ? 16'h0 : a << b;
        4'd9: rr = (b >= 16) ? 16'h0 : a >> b;
        4'd10: begin
          t = sa >>> ((b >= 16) ? 16 : int'(b));
          rr = t[15:0];
        end
        default: rr = 0;
      endcase
    end
    return {rr, o, rr[15], rr == 16'h0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("sb_has_entry", q.size(), 1);
        else begin
          chk("sb_result", {out, flags}, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(opcode, in_a, in_b, sat_en));
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic s);
    bit ok = 0;
    opcode = op;
    in_a = a;
    in_b = b;
    sat_en = s;
    in_valid = 1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic s, input logic [15:0] eo,
                     input logic [2:0] ef);
    send(op, a, b, s);
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, out_valid, 0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_flags"}, flags, ef);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) chk("valid_timeout", ok, 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 64 && (q.size() != 0 || out_valid); k++) @(negedge clk);
    chk(tag, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int base;
    logic [3:0] rop;
    logic [15:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    run("add_wrap", 4'h0, 16'h7fff, 16'h0001, 0, 16'h8000, 3'b110);
    run("add_sat", 4'h0, 16'h7fff, 16'h0001, 1, 16'h7fff, 3'b100);
    run("sub_sat", 4'h1, 16'h8000, 16'h0001, 1, 16'h8000, 3'b110);
    run("sub_wrap", 4'h1, 16'h8000, 16'h0001, 0, 16'h7fff, 3'b100);
    run("add_nsat", 4'h0, 16'h8000, 16'hffff, 1, 16'h8000, 3'b110);
    run("sra_big", 4'hA, 16'h8000, 16'd20, 0, 16'hffff, 3'b010);
    run("sra_4", 4'hA, 16'h8000, 16'd4, 0, 16'hf800, 3'b010);
    run("shl_15", 4'h8, 16'h0001, 16'd15, 0, 16'h8000, 3'b010);
    run("shl_0", 4'h8, 16'h1234, 16'd0, 0, 16'h1234, 3'b000);
    run("shr_16", 4'h9, 16'h1234, 16'd16, 0, 16'h0000, 3'b001);
    run("inc_max", 4'h5, 16'h7fff, 16'h0, 0, 16'h8000, 3'b110);
    run("dec_min", 4'hB, 16'h8000, 16'h0, 0, 16'h7fff, 3'b100);
    run("dec_sat", 4'hB, 16'h8000, 16'h0, 1, 16'h8000, 3'b110);
    run("op_e", 4'hE, 16'h1234, 16'h5678, 0, 16'h0000, 3'b001);
    run("and", 4'h2, 16'hf0f0, 16'h0ff0, 0, 16'h00f0, 3'b000);
    run("or", 4'h3, 16'h0f00, 16'h00f0, 0, 16'h0ff0, 3'b000);
    run("xor", 4'h4, 16'hffff, 16'hffff, 1, 16'h0000, 3'b001);
    run("pass_b", 4'h7, 16'h0000, 16'h8001, 0, 16'h8001, 3'b010);
    base = n_out;
    send(4'h0, 16'd1, 16'd1, 0);
    send(4'h0, 16'd2, 16'd2, 0);
    fork
      begin
        send(4'h0, 16'd3, 16'd3, 0);
        send(4'h0, 16'd4, 16'd4, 0);
      end
      begin
        out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_out", out, 16'h0002);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - base, 4);
    ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("sticky_pre", ovf_sticky, 0);
    send(4'h0, 16'h7fff, 16'h0001, 0);
    wait_valid();
    ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("sticky_set_wins", ovf_sticky, 1);
    ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("sticky_clr", ovf_sticky, 0);
    send(4'h0, 16'h7fff, 16'h0001, 0);
    send(4'h0, 16'h0001, 16'h0001, 0);
    rst_n = 0;
    in_valid = 1;
    opcode = 4'h6;
    in_a = 16'h5555;
    @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    done = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (out_valid) done = 1;
    end
    chk("mid_rst_no_ghost", done, 0);
    @(posedge clk);
    #1;
    run("post_rst", 4'h6, 16'h1234, 16'h0, 0, 16'h1234, 3'b000);
    done = 0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          rop = 4'($urandom_range(0, 15));
          ra = 16'($urandom);
          rb = (rop inside {4'h8, 4'h9, 4'hA}) ? 16'($urandom_range(0, 20)) : 16'($urandom);
          send(rop, ra, rb, 1'($urandom_range(0, 1)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain("rand_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
